// File: rtl/usart_pkg.sv
// Shared definitions for the usart loopback path (tx state encoding, bit timing helpers, line levels).
// Build option: USART_TX_PARITY_EN adds the PARITY state to the tx state enum.
// No logic here; consumers import usart_pkg::*.
package usart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

`ifdef USART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    // Clocks per serial bit; integer division, any remainder is dropped.
    function automatic int unsigned calc_b_cnt(input int unsigned s_clk, input int unsigned baud);
        return s_clk / baud;
    endfunction

endpackage

// File: rtl/usart_tx_if.sv
// Byte-strobe input and serial/status outputs of the usart transmit stage.
// master: the upstream receiver side (drives strobe+byte, observes status).
// slave : the transmitter itself.
interface usart_tx_if;

    logic       data_en;
    logic [7:0] data_in;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overrun;

    modport master (
        output data_en,
        output data_in,
        input  tx_out,
        input  tx_busy,
        input  tx_done,
        input  tx_overrun
    );

    modport slave (
        input  data_en,
        input  data_in,
        output tx_out,
        output tx_busy,
        output tx_done,
        output tx_overrun
    );

endinterface

// File: rtl/usart_baud_cnt.sv
// Purpose: bit-period counter, counts 0..CNT_MAX-1 while enabled and wraps at the end of each bit.
// Latency: o_bit_end is combinational, high during the last clock of a bit period.
// Backpressure: none; i_clr holds the count at zero, i_en gates counting.
module usart_baud_cnt #(
    parameter int unsigned CNT_MAX = 434
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_bit_end
);

    logic [15:0] r_cnt;
    logic        w_at_end;

    assign w_at_end  = (r_cnt == 16'(CNT_MAX - 1));
    assign o_bit_end = i_en & w_at_end;

    // Free-running bit counter; clear wins over enable so a new frame always starts at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en) begin
            r_cnt <= w_at_end ? 16'd0 : r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/usart_tx.sv
// Purpose: serialise received bytes as 8N1 (8E1/8O1 when USART_TX_PARITY_EN is defined) on tx_out.
// Latency: start bit appears the cycle after data_en; a frame lasts 10*B_CNT clocks (11*B_CNT with parity).
// Backpressure: none upstream; one-deep holding buffer, a third byte during a frame is dropped and tx_overrun pulses.
module usart_tx
    import usart_pkg::*;
#(
    parameter int BOUNDS     = 115200,
    parameter int S_CLK      = 50_000_000,
    parameter int PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    usart_tx_if.slave  bus
);

    localparam int unsigned B_CNT = calc_b_cnt(S_CLK, BOUNDS);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] r_buf;
    logic       r_buf_full;
    logic [2:0] r_bit_idx;
    logic       r_busy;
    logic       r_overrun;
    logic       w_idle;
    logic       w_bit_end;
    logic       w_stop_end;
    logic       w_last_bit;
    logic       w_tx_out;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_stop_end = (r_state == ST_STOP) && w_bit_end;
    assign w_last_bit = (r_bit_idx == 3'(DATA_BITS - 1));

    usart_baud_cnt #(
        .CNT_MAX (B_CNT)
    ) u_baud_cnt (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_en      (!w_idle),
        .i_clr     (w_idle),
        .o_bit_end (w_bit_end)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and line-level decode.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_out    = IDLE_LEVEL;
        case (r_state)
            ST_IDLE: begin
                if (bus.data_en) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_tx_out = START_LEVEL;
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_out = r_shift[r_bit_idx];
`ifdef USART_TX_PARITY_EN
                if (w_bit_end && w_last_bit) w_state_nxt = ST_PARITY;
`else
                if (w_bit_end && w_last_bit) w_state_nxt = ST_STOP;
`endif
            end
`ifdef USART_TX_PARITY_EN
            ST_PARITY: begin
                w_tx_out = (^r_shift) ^ (PARITY_ODD != 0);
                if (w_bit_end) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                w_tx_out = STOP_LEVEL;
                // A byte that is pending, or arrives on this very clock, starts with no idle gap.
                if (w_bit_end) w_state_nxt = (r_buf_full || bus.data_en) ? ST_START : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Data bit index, LSB first; wraps 7->0 naturally at the end of the data phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit_idx <= 3'd0;
        end else if (w_idle) begin
            r_bit_idx <= 3'd0;
        end else if ((r_state == ST_DATA) && w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Shift register and one-deep holding buffer with overrun detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shift    <= 8'd0;
            r_buf      <= 8'd0;
            r_buf_full <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_idle) begin
                if (bus.data_en) r_shift <= bus.data_in;
            end else if (w_stop_end) begin
                if (r_buf_full) begin
                    // Buffer drains into the shifter; a coincident byte refills it.
                    r_shift    <= r_buf;
                    r_buf_full <= bus.data_en;
                    if (bus.data_en) r_buf <= bus.data_in;
                end else if (bus.data_en) begin
                    r_shift <= bus.data_in;
                end
            end else if (bus.data_en) begin
                if (r_buf_full) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_buf      <= bus.data_in;
                    r_buf_full <= 1'b1;
                end
            end
        end
    end

    // Busy flag. The buffer can only be full while a frame is active or about to
    // restart, so the next state alone covers "frame running or byte pending".
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.tx_out     = w_tx_out;
    assign bus.tx_busy    = r_busy;
    assign bus.tx_done    = w_stop_end;
    assign bus.tx_overrun = r_overrun;

endmodule

// File: tb/tb_usart_tx.sv
// Directed bench for usart_tx at B_CNT=10 (S_CLK=1MHz, BOUNDS=100k).
// Outputs are sampled on the falling edge; inputs are driven right after sampling.
// Honours USART_TX_PARITY_EN (even parity) for frame length and the parity bit.
module tb_usart_tx;

    localparam int B = 10;
`ifdef USART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * B;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    usart_tx_if bus ();

    usart_tx #(
        .BOUNDS     (100_000),
        .S_CLK      (1_000_000),
        .PARITY_ODD (0)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected line level k clocks (0-based) into a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / B;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef USART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Expected line level on cycle c (1 = first cycle after the first strobe) for n queued frames.
    function automatic logic exp_line(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input int n, input int c);
        int f;
        f = (c - 1) / FRAME;
        if (f >= n) return 1'b1;
        if (f == 0) return exp_bit(b0, (c - 1) % FRAME);
        if (f == 1) return exp_bit(b1, (c - 1) % FRAME);
        return exp_bit(b2, (c - 1) % FRAME);
    endfunction

    task automatic test_reset();
        bus.data_en = 1'b0;
        bus.data_in = 8'h00;
        sys_rst_n   = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (bus.tx_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 || bus.tx_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out/busy/done/ovr got %b%b%b%b want 1000",
                     bus.tx_out, bus.tx_busy, bus.tx_done, bus.tx_overrun);
        end
        sys_rst_n = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge sys_clk);
            checks++;
            if (bus.tx_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 || bus.tx_overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d out/busy/done/ovr got %b%b%b%b want 1000",
                         c, bus.tx_out, bus.tx_busy, bus.tx_done, bus.tx_overrun);
            end
        end
    endtask

    task automatic test_single();
        logic e_out;
        bus.data_en = 1'b1;
        bus.data_in = 8'hA5;
        for (int c = 1; c <= FRAME + 1; c++) begin
            @(negedge sys_clk);
            bus.data_en = 1'b0;
            e_out = exp_line(8'hA5, 8'h00, 8'h00, 1, c);
            checks++;
            if (bus.tx_out !== e_out) begin
                errors++;
                $display("FAIL single tx_out cycle %0d got %b want %b", c, bus.tx_out, e_out);
            end
            checks++;
            if (bus.tx_done !== (c == FRAME)) begin
                errors++;
                $display("FAIL single tx_done cycle %0d got %b want %b", c, bus.tx_done, (c == FRAME));
            end
            checks++;
            if (bus.tx_busy !== (c <= FRAME)) begin
                errors++;
                $display("FAIL single tx_busy cycle %0d got %b want %b", c, bus.tx_busy, (c <= FRAME));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e_out;
        bus.data_en = 1'b1;
        bus.data_in = 8'h55;
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(negedge sys_clk);
            e_out = exp_line(8'h55, 8'h0F, 8'h00, 2, c);
            checks++;
            if (bus.tx_out !== e_out || bus.tx_overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b cycle %0d out/ovr got %b%b want %b0", c, bus.tx_out, bus.tx_overrun, e_out);
            end
            checks++;
            if (bus.tx_done !== (c == FRAME || c == 2 * FRAME) || bus.tx_busy !== (c <= 2 * FRAME)) begin
                errors++;
                $display("FAIL b2b cycle %0d done/busy got %b%b want %b%b", c, bus.tx_done, bus.tx_busy,
                         (c == FRAME || c == 2 * FRAME), (c <= 2 * FRAME));
            end
            bus.data_en = (c == 30);
            bus.data_in = 8'h0F;
        end
    endtask

    task automatic test_overrun();
        logic e_out;
        bus.data_en = 1'b1;
        bus.data_in = 8'h01;
        for (int c = 1; c <= 2 * FRAME + 1; c++) begin
            @(negedge sys_clk);
            e_out = exp_line(8'h01, 8'h02, 8'h00, 2, c);
            checks++;
            if (bus.tx_out !== e_out) begin
                errors++;
                $display("FAIL overrun tx_out cycle %0d got %b want %b", c, bus.tx_out, e_out);
            end
            checks++;
            if (bus.tx_overrun !== (c == 11)) begin
                errors++;
                $display("FAIL overrun pulse cycle %0d got %b want %b", c, bus.tx_overrun, (c == 11));
            end
            bus.data_en = (c == 5) || (c == 10);
            bus.data_in = (c == 5) ? 8'h02 : 8'h03;
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun tx_busy after frames got %b want 0", bus.tx_busy);
        end
    endtask

    task automatic test_coincident();
        logic e_out;
        bus.data_en = 1'b1;
        bus.data_in = 8'h11;
        for (int c = 1; c <= 3 * FRAME + 1; c++) begin
            @(negedge sys_clk);
            e_out = exp_line(8'h11, 8'h22, 8'h7E, 3, c);
            checks++;
            if (bus.tx_out !== e_out || bus.tx_overrun !== 1'b0) begin
                errors++;
                $display("FAIL coincident cycle %0d out/ovr got %b%b want %b0", c, bus.tx_out, bus.tx_overrun, e_out);
            end
            checks++;
            if (bus.tx_busy !== (c <= 3 * FRAME)) begin
                errors++;
                $display("FAIL coincident tx_busy cycle %0d got %b want %b", c, bus.tx_busy, (c <= 3 * FRAME));
            end
            // Strobe on the last stop clock of frame 1 while 8'h22 is still buffered.
            bus.data_en = (c == 5) || (c == FRAME);
            bus.data_in = (c == 5) ? 8'h22 : 8'h7E;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic e_out;
        bus.data_en = 1'b1;
        bus.data_in = 8'hFF;
        for (int c = 1; c <= 45; c++) begin
            @(negedge sys_clk);
            bus.data_en = 1'b0;
        end
        checks++;
        if (bus.tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst busy before reset got %b want 1", bus.tx_busy);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tx_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst immediate out/busy/done got %b%b%b want 100", bus.tx_out, bus.tx_busy, bus.tx_done);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (bus.tx_out !== 1'b1 || bus.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst after release out/busy got %b%b want 10", bus.tx_out, bus.tx_busy);
        end
        bus.data_en = 1'b1;
        bus.data_in = 8'h3C;
        for (int c = 1; c <= FRAME + 1; c++) begin
            @(negedge sys_clk);
            bus.data_en = 1'b0;
            e_out = exp_line(8'h3C, 8'h00, 8'h00, 1, c);
            checks++;
            if (bus.tx_out !== e_out || bus.tx_done !== (c == FRAME)) begin
                errors++;
                $display("FAIL midrst clean frame cycle %0d out/done got %b%b want %b%b",
                         c, bus.tx_out, bus.tx_done, e_out, (c == FRAME));
            end
        end
    endtask

`ifdef USART_TX_PARITY_EN
    task automatic test_parity();
        bus.data_en = 1'b1;
        bus.data_in = 8'h07;
        for (int c = 1; c <= FRAME + 1; c++) begin
            @(negedge sys_clk);
            bus.data_en = 1'b0;
            // 8'h07 has three ones: even-parity bit is 1, sent on cycles 91..100.
            if (c == 95) begin
                checks++;
                if (bus.tx_out !== 1'b1) begin
                    errors++;
                    $display("FAIL parity bit got %b want 1", bus.tx_out);
                end
            end
            if (c == FRAME) begin
                checks++;
                if (bus.tx_done !== 1'b1) begin
                    errors++;
                    $display("FAIL parity frame length done at %0d got %b want 1", c, bus.tx_done);
                end
            end
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL parity busy after frame got %b want 0", bus.tx_busy);
        end
    endtask
`endif

    initial begin
        bus.data_en = 1'b0;
        bus.data_in = 8'h00;
        test_reset();
        test_single();
        repeat (5) @(negedge sys_clk);
        test_back_to_back();
        repeat (5) @(negedge sys_clk);
        test_overrun();
        repeat (5) @(negedge sys_clk);
        test_coincident();
        repeat (5) @(negedge sys_clk);
        test_reset_mid_frame();
`ifdef USART_TX_PARITY_EN
        repeat (5) @(negedge sys_clk);
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
